// File: rtl/sysx_pkg.sv
// sysx_pkg: shared definitions for the sysX bus endpoints.
// The state encoding is shared with the master pipeline and must not be renumbered.
package sysx_pkg;

    typedef enum logic [2:0] {
        sIdle  = 3'd0,
        sLoad  = 3'd1,
        sLoLo  = 3'd2,
        sLo    = 3'd3,
        sHi    = 3'd4,
        sHiHi  = 3'd5,
        sStore = 3'd6
    } sysxState_t;

    localparam logic [1:0]  cSelectIdle = 2'h0;
    localparam logic [31:0] cIdleWord   = 32'hFFFFFFFF;

    // Byte lane a slave drives in a given state; byte states walk the word LSB first,
    // every other state leaves the lane at the idle pattern.
    function automatic logic [7:0] misoByte(input sysxState_t state, input logic [31:0] word);
        logic [7:0] result;
        result = 8'hFF;
        case (state)
            sLoLo:   result = word[7:0];
            sLo:     result = word[15:8];
            sHi:     result = word[23:16];
            sHiHi:   result = word[31:24];
            default: result = 8'hFF;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/sysx_sync.sv
// sysx_sync: 2-flop synchronizer for a group of bus pins, with an edge detect on bit 0.
// Bit 0 carries the bus clock, so the remaining bits are aligned with its edges.
module sysx_sync #(
    parameter int                pWidth      = 1,
    parameter logic [pWidth-1:0] pResetValue = '0
) (
    input  logic              iClock,
    input  logic              iReset,
    input  logic [pWidth-1:0] iData,
    output logic [pWidth-1:0] oData,
    output logic              oRise,
    output logic              oFall
);

    logic [pWidth-1:0] metaReg;
    logic [pWidth-1:0] syncReg;
    logic              prevBit;

    // Two synchronizer stages plus a history flop of bit 0 for edge detection.
    always_ff @(posedge iClock or negedge iReset) begin
        if (!iReset) begin
            metaReg <= pResetValue;
            syncReg <= pResetValue;
            prevBit <= pResetValue[0];
        end else begin
            metaReg <= iData;
            syncReg <= metaReg;
            prevBit <= syncReg[0];
        end
    end

    assign oData = syncReg;
    assign oRise = syncReg[0] & ~prevBit;
    assign oFall = ~syncReg[0] & prevBit;

endmodule

// File: rtl/sysx_slave.sv
// sysx_slave: sysX bus responder exchanging 32-bit words, four bytes LSB first.
// Optional feature: define SYSX_SLAVE_IRQ_EN to let local logic raise the bus interrupt.
module sysx_slave
    import sysx_pkg::*;
#(
    parameter logic [1:0]  pSelect   = 2'h1,
    parameter logic [31:0] pIdleWord = cIdleWord
) (
    input  logic        iClock,
    input  logic        iReset,
    input  logic        iBusClock,
    input  logic [1:0]  iBusSelect,
    input  logic [7:0]  iBusMOSI,
    output logic [7:0]  oBusMISO,
    output logic        oBusMISOEnable,
    output logic        oBusInterrupt,
    input  logic [31:0] iTxData,
    input  logic        iTxValid,
    output logic        oTxReady,
    output logic [31:0] oRxData,
    output logic        oRxValid,
    output logic        oUnderrun,
    output logic        oAbort,
    input  logic        iIrqRequest
);

    logic [10:0] syncBus;
    logic        busRise;
    logic        busFall;
    logic [1:0]  syncSelect;
    logic [7:0]  syncMosi;

    sysx_sync #(
        .pWidth      (11),
        .pResetValue ({8'h00, cSelectIdle, 1'b1})
    ) busSync (
        .iClock (iClock),
        .iReset (iReset),
        .iData  ({iBusMOSI, iBusSelect, iBusClock}),
        .oData  (syncBus),
        .oRise  (busRise),
        .oFall  (busFall)
    );

    assign syncSelect = syncBus[2:1];
    assign syncMosi   = syncBus[10:3];

    sysxState_t  state;
    sysxState_t  stateNext;
    logic        selected;
    logic        byteState;
    logic        enterLoad;
    logic        enterStore;
    logic        abortNext;
    logic        captureByte;
    logic [7:0]  misoNext;

    logic [31:0] shiftReg;
    logic [31:0] rxShift;
    logic [31:0] holdReg;
    logic        holdFull;
    logic        txLoad;

    assign selected  = (syncSelect == pSelect);
    assign byteState = (state == sLoLo) || (state == sLo) || (state == sHi) || (state == sHiHi);
    assign txLoad    = iTxValid && !holdFull;
    assign oTxReady  = !holdFull;
    assign oBusMISOEnable = (state != sIdle);

    // State register.
    always_ff @(posedge iClock or negedge iReset) begin
        if (!iReset) begin
            state <= sIdle;
        end else begin
            state <= stateNext;
        end
    end

    // Next state: losing select always wins, otherwise each bus rising edge advances.
    always_comb begin
        stateNext = state;
        case (state)
            sIdle: begin
                if (selected) stateNext = sLoad;
            end
            default: begin
                if (!selected) begin
                    stateNext = sIdle;
                end else if (busRise) begin
                    case (state)
                        sLoad:   stateNext = sLoLo;
                        sLoLo:   stateNext = sLo;
                        sLo:     stateNext = sHi;
                        sHi:     stateNext = sHiHi;
                        sHiHi:   stateNext = sStore;
                        sStore:  stateNext = sLoad;
                        default: stateNext = sIdle;
                    endcase
                end
            end
        endcase
    end

    // Decoded actions for this cycle, registered by the datapath below.
    always_comb begin
        enterLoad   = (stateNext == sLoad) && (state != sLoad);
        enterStore  = (stateNext == sStore) && (state != sStore);
        abortNext   = byteState && !selected;
        captureByte = byteState && selected && busFall;
        misoNext    = misoByte(stateNext, shiftReg);
    end

    // Shift/receive datapath and registered status pulses.
    always_ff @(posedge iClock or negedge iReset) begin
        if (!iReset) begin
            shiftReg  <= pIdleWord;
            rxShift   <= 32'h0;
            oRxData   <= 32'h0;
            oRxValid  <= 1'b0;
            oUnderrun <= 1'b0;
            oAbort    <= 1'b0;
            oBusMISO  <= 8'hFF;
        end else begin
            oBusMISO  <= misoNext;
            oRxValid  <= enterStore;
            oUnderrun <= enterLoad && !holdFull;
            oAbort    <= abortNext;
            if (enterLoad) begin
                shiftReg <= holdFull ? holdReg : pIdleWord;
            end else if (stateNext == sIdle) begin
                shiftReg <= pIdleWord;
            end
            if (stateNext == sIdle) begin
                rxShift <= 32'h0;
            end else if (captureByte) begin
                case (state)
                    sLoLo:   rxShift[7:0]   <= syncMosi;
                    sLo:     rxShift[15:8]  <= syncMosi;
                    sHi:     rxShift[23:16] <= syncMosi;
                    sHiHi:   rxShift[31:24] <= syncMosi;
                    default: rxShift        <= rxShift;
                endcase
            end
            if (enterStore) begin
                oRxData <= rxShift;
            end
        end
    end

    // One-word transmit holding register; a load in the same cycle as a transfer keeps it full.
    always_ff @(posedge iClock or negedge iReset) begin
        if (!iReset) begin
            holdReg  <= 32'h0;
            holdFull <= 1'b0;
        end else if (txLoad) begin
            holdReg  <= iTxData;
            holdFull <= 1'b1;
        end else if (enterLoad) begin
            holdFull <= 1'b0;
        end
    end

`ifdef SYSX_SLAVE_IRQ_EN
    logic irqPending;

    // Pending interrupt: set by local request, cleared by the next received word; set wins.
    always_ff @(posedge iClock or negedge iReset) begin
        if (!iReset) begin
            irqPending <= 1'b0;
        end else if (iIrqRequest) begin
            irqPending <= 1'b1;
        end else if (oRxValid) begin
            irqPending <= 1'b0;
        end
    end

    assign oBusInterrupt = irqPending;
`else
    logic unusedIrqRequest;

    assign unusedIrqRequest = iIrqRequest;
    assign oBusInterrupt    = 1'b0;
`endif

endmodule

// File: tb/tb_sysx_slave.sv
// tb_sysx_slave: directed bench for sysx_slave acting as a sysX master at iClock/16.
module tb_sysx_slave;

    logic        iClock = 1'b0;
    logic        iReset = 1'b0;
    logic        iBusClock = 1'b1;
    logic [1:0]  iBusSelect = 2'h0;
    logic [7:0]  iBusMOSI = 8'h00;
    logic [7:0]  oBusMISO;
    logic        oBusMISOEnable;
    logic        oBusInterrupt;
    logic [31:0] iTxData = 32'h0;
    logic        iTxValid = 1'b0;
    logic        oTxReady;
    logic [31:0] oRxData;
    logic        oRxValid;
    logic        oUnderrun;
    logic        oAbort;
    logic        iIrqRequest = 1'b0;

    int          assertCount = 0;
    int          failCount = 0;
    int          rxCount = 0;
    int          underrunCount = 0;
    int          abortCount = 0;
    logic [31:0] lastRx = 32'h0;
    logic [31:0] misoWord;
    logic        irqExpect;

    sysx_slave #(
        .pSelect   (2'h1),
        .pIdleWord (32'hFFFFFFFF)
    ) dut (
        .iClock         (iClock),
        .iReset         (iReset),
        .iBusClock      (iBusClock),
        .iBusSelect     (iBusSelect),
        .iBusMOSI       (iBusMOSI),
        .oBusMISO       (oBusMISO),
        .oBusMISOEnable (oBusMISOEnable),
        .oBusInterrupt  (oBusInterrupt),
        .iTxData        (iTxData),
        .iTxValid       (iTxValid),
        .oTxReady       (oTxReady),
        .oRxData        (oRxData),
        .oRxValid       (oRxValid),
        .oUnderrun      (oUnderrun),
        .oAbort         (oAbort),
        .iIrqRequest    (iIrqRequest)
    );

    // Local clock, 10 ns period.
    always #5 iClock = ~iClock;

    // Pulse monitor, sampled on the falling local clock edge.
    always @(negedge iClock) begin
        if (oRxValid) begin
            rxCount <= rxCount + 1;
            lastRx  <= oRxData;
        end
        if (oUnderrun) underrunCount <= underrunCount + 1;
        if (oAbort) abortCount <= abortCount + 1;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic busHalf();
        repeat (8) @(negedge iClock);
    endtask

    task automatic applyStimulus(input logic [31:0] data);
        @(negedge iClock);
        iTxValid = 1'b1;
        iTxData  = data;
        @(negedge iClock);
        iTxValid = 1'b0;
    endtask

    task automatic busRiseHalf(input logic [7:0] mosi);
        iBusClock = 1'b1;
        iBusMOSI  = mosi;
        busHalf();
    endtask

    task automatic busFallHalf();
        iBusClock = 1'b0;
        busHalf();
    endtask

    // Shifts one word from sLoad through to sStore, returning the MISO bytes seen.
    task automatic shiftWord(input logic [31:0] mosiWord, output logic [31:0] seen);
        seen = 32'h0;
        for (int i = 0; i < 4; i++) begin
            busFallHalf();
            busRiseHalf(mosiWord[8*i +: 8]);
            seen[8*i +: 8] = oBusMISO;
        end
        busFallHalf();
        busRiseHalf(8'h00);
    endtask

    // Block continuation: sStore back to sLoad.
    task automatic nextWord();
        busFallHalf();
        busRiseHalf(8'h00);
    endtask

    initial begin
`ifdef SYSX_SLAVE_IRQ_EN
        irqExpect = 1'b1;
`else
        irqExpect = 1'b0;
`endif
        $display("[TB] reset state");
        repeat (3) @(negedge iClock);
        checkOutput("rstMISO", {24'h0, oBusMISO}, 32'h000000FF);
        checkOutput("rstEnable", {31'h0, oBusMISOEnable}, 32'h0);
        checkOutput("rstIrq", {31'h0, oBusInterrupt}, 32'h0);
        checkOutput("rstTxReady", {31'h0, oTxReady}, 32'h1);
        checkOutput("rstRxData", oRxData, 32'h0);
        checkOutput("rstPulses", {29'h0, oRxValid, oUnderrun, oAbort}, 32'h0);
        iReset = 1'b1;
        busHalf();

        $display("[TB] single transfer");
        applyStimulus(32'hCAFEF00D);
        checkOutput("txLoaded", {31'h0, oTxReady}, 32'h0);
        iBusSelect = 2'h1;
        busHalf();
        checkOutput("singleEnable", {31'h0, oBusMISOEnable}, 32'h1);
        checkOutput("singleTxReady", {31'h0, oTxReady}, 32'h1);
        shiftWord(32'h12345678, misoWord);
        checkOutput("singleMISO", misoWord, 32'hCAFEF00D);
        checkOutput("singleRx", lastRx, 32'h12345678);
        checkOutput("singleRxCount", rxCount, 32'd1);
        checkOutput("singleUnderrun", underrunCount, 32'd0);
        iBusSelect = 2'h0;
        busHalf();
        checkOutput("singleIdle", {31'h0, oBusMISOEnable}, 32'h0);

        $display("[TB] block of three, holding register empty");
        iBusSelect = 2'h1;
        busHalf();
        shiftWord(32'hA5A5A5A5, misoWord);
        checkOutput("blk0MISO", misoWord, 32'hFFFFFFFF);
        checkOutput("blk0Rx", lastRx, 32'hA5A5A5A5);
        nextWord();
        shiftWord(32'h0F0F1234, misoWord);
        checkOutput("blk1MISO", misoWord, 32'hFFFFFFFF);
        checkOutput("blk1Rx", lastRx, 32'h0F0F1234);
        nextWord();
        shiftWord(32'hDEADBEEF, misoWord);
        checkOutput("blk2MISO", misoWord, 32'hFFFFFFFF);
        checkOutput("blk2Rx", lastRx, 32'hDEADBEEF);
        iBusSelect = 2'h0;
        busHalf();
        checkOutput("blkUnderrun", underrunCount, 32'd3);
        checkOutput("blkRxCount", rxCount, 32'd4);
        checkOutput("blkAbort", abortCount, 32'd0);

        $display("[TB] foreign select code");
        iBusSelect = 2'h2;
        for (int i = 0; i < 4; i++) begin
            busFallHalf();
            busRiseHalf(8'h3C);
            checkOutput("sel2Enable", {31'h0, oBusMISOEnable}, 32'h0);
        end
        iBusSelect = 2'h0;
        busHalf();
        checkOutput("sel2RxCount", rxCount, 32'd4);

        $display("[TB] select dropped in sLo");
        iBusSelect = 2'h1;
        busHalf();
        busFallHalf();
        busRiseHalf(8'h11);
        busFallHalf();
        busRiseHalf(8'h22);
        busFallHalf();
        iBusSelect = 2'h0;
        busHalf();
        busRiseHalf(8'h00);
        checkOutput("abortCount", abortCount, 32'd1);
        checkOutput("abortRxData", oRxData, 32'hDEADBEEF);
        checkOutput("abortRxCount", rxCount, 32'd4);
        checkOutput("abortIdle", {31'h0, oBusMISOEnable}, 32'h0);
        checkOutput("abortMISO", {24'h0, oBusMISO}, 32'h000000FF);
        applyStimulus(32'h0BADCAFE);
        iBusSelect = 2'h1;
        busHalf();
        shiftWord(32'h87654321, misoWord);
        checkOutput("recoverMISO", misoWord, 32'h0BADCAFE);
        checkOutput("recoverRx", lastRx, 32'h87654321);
        iBusSelect = 2'h0;
        busHalf();

        $display("[TB] reset during sHi");
        applyStimulus(32'h11223344);
        iBusSelect = 2'h1;
        busHalf();
        busFallHalf();
        busRiseHalf(8'hAA);
        busFallHalf();
        busRiseHalf(8'hBB);
        busFallHalf();
        busRiseHalf(8'hCC);
        checkOutput("preRstMISO", {24'h0, oBusMISO}, 32'h00000022);
        applyStimulus(32'h55667788);
        checkOutput("preRstTxReady", {31'h0, oTxReady}, 32'h0);
        @(negedge iClock);
        iReset = 1'b0;
        #1;
        checkOutput("asyncMISO", {24'h0, oBusMISO}, 32'h000000FF);
        checkOutput("asyncEnable", {31'h0, oBusMISOEnable}, 32'h0);
        checkOutput("asyncTxReady", {31'h0, oTxReady}, 32'h1);
        checkOutput("asyncRxData", oRxData, 32'h0);
        checkOutput("asyncPulses", {29'h0, oRxValid, oUnderrun, oAbort}, 32'h0);
        iBusSelect = 2'h0;
        repeat (4) @(negedge iClock);
        iReset = 1'b1;
        busHalf();
        checkOutput("postRstRxCount", rxCount, 32'd5);
        checkOutput("postRstAbort", abortCount, 32'd1);
        checkOutput("postRstEnable", {31'h0, oBusMISOEnable}, 32'h0);

        $display("[TB] interrupt request");
        @(negedge iClock);
        iIrqRequest = 1'b1;
        @(negedge iClock);
        iIrqRequest = 1'b0;
        #1;
        checkOutput("irqSet", {31'h0, oBusInterrupt}, {31'h0, irqExpect});
        iBusSelect = 2'h1;
        busHalf();
        shiftWord(32'h5A5A0001, misoWord);
        checkOutput("irqRx", lastRx, 32'h5A5A0001);
        checkOutput("irqCleared", {31'h0, oBusInterrupt}, 32'h0);
        iBusSelect = 2'h0;
        busHalf();
        checkOutput("irqIdle", {31'h0, oBusInterrupt}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
